cci_rd_port_mux: RTL and testbench

// Parametrised N-port read-request multiplexer between PipeArch engines and the MPF c0 channel.

---
 rtl/cci_rd_port_mux.sv | 172 +++++++++++++++++
 tb/tb_cci_rd_port_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cci_rd_port_mux.sv
// cci_rd_port_mux: N-port read-request mux onto the c0 channel with
// port-ID tagging in mdata, response routing and per-port outstanding caps.

// Per-port lane: request FIFO, outstanding-read counter, registered ready.
module cci_rd_port_lane #(
  parameter int ADDR_W          = 42,
  parameter int UM_W            = 14,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [UM_W-1:0]   in_tag,
  input  logic              pop,
  input  logic              rsp_done,
  output logic              ready,
  output logic              empty,
  output logic              cnt_zero,
  output logic [ADDR_W-1:0] head_addr,
  output logic [UM_W-1:0]   head_tag
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;

  logic [ADDR_W+UM_W-1:0]     mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level, level_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       push;

  assign push      = in_valid & ready;
  assign level_nxt = level + LW'(push) - LW'(pop);
  // rsp_done is only asserted when cnt != 0, so this never wraps below zero
  assign cnt_nxt   = cnt + CNT_W'(push) - CNT_W'(rsp_done);
  assign empty     = (level == '0);
  assign cnt_zero  = (cnt == '0);
  assign head_addr = mem[rd_ptr][ADDR_W+UM_W-1:UM_W];
  assign head_tag  = mem[rd_ptr][UM_W-1:0];

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_addr, in_tag};
  end

  // Pointers, level, counter; ready looks ahead at next-state so it is a clean flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      cnt   <= cnt_nxt;
      ready <= (level_nxt != LW'(DEPTH)) && (cnt_nxt < CNT_W'(MAX_OUTSTANDING));
    end
  end
endmodule

module cci_rd_port_mux #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int DATA_W          = 512,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int MAX_OUTSTANDING = 64,
  localparam int PID_W          = $clog2(NUM_PORTS),
  localparam int UM_W           = MDATA_W - PID_W,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
)(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        port_rd_valid,
  output logic [NUM_PORTS-1:0]        port_rd_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr,
  input  logic [NUM_PORTS*UM_W-1:0]   port_rd_mdata,
  output logic                        c0tx_valid,
  output logic [ADDR_W-1:0]           c0tx_addr,
  output logic [MDATA_W-1:0]          c0tx_mdata,
  input  logic                        c0tx_almfull,
  input  logic                        c0rx_valid,
  input  logic [MDATA_W-1:0]          c0rx_mdata,
  input  logic [DATA_W-1:0]           c0rx_data,
  output logic [NUM_PORTS-1:0]        port_rsp_valid,
  output logic [UM_W-1:0]             port_rsp_mdata,
  output logic [DATA_W-1:0]           port_rsp_data,
  output logic                        idle,
  output logic                        err_sticky
);
  logic [PID_W-1:0]                  ptr, ptr_nxt, grant, rx_id;
  logic                              grant_vld, rx_bad;
  logic [NUM_PORTS-1:0]              empty, cnt_zero, pop, rsp_hit;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]  head_addr;
  logic [NUM_PORTS-1:0][UM_W-1:0]    head_tag;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    cci_rd_port_lane #(
      .ADDR_W(ADDR_W), .UM_W(UM_W), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2),
      .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)
    ) u_lane (
      .clk(clk), .reset_n(reset_n),
      .in_valid(port_rd_valid[g]),
      .in_addr(port_rd_addr[g*ADDR_W +: ADDR_W]),
      .in_tag(port_rd_mdata[g*UM_W +: UM_W]),
      .pop(pop[g]), .rsp_done(rsp_hit[g]),
      .ready(port_rd_ready[g]), .empty(empty[g]), .cnt_zero(cnt_zero[g]),
      .head_addr(head_addr[g]), .head_tag(head_tag[g])
    );
  end

  // Round-robin grant: first non-empty port at or after ptr, wrapping; nothing while almfull
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    pop       = '0;
    idx       = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_vld && !empty[idx] && !c0tx_almfull) begin
        grant_vld = 1'b1;
        grant     = PID_W'(idx);
      end
    end
    if (grant_vld) pop[grant] = 1'b1;
    ptr_nxt = (grant == PID_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  end

  // Response decode; an ID with no matching port or nothing outstanding is an error
  always_comb begin
    rx_id = c0rx_mdata[MDATA_W-1 -: PID_W];
    for (int i = 0; i < NUM_PORTS; i++)
      rsp_hit[i] = c0rx_valid && (rx_id == PID_W'(i)) && !cnt_zero[i];
    rx_bad = c0rx_valid && (rsp_hit == '0);
  end

  // Registered c0tx issue, response routing, idle and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr            <= '0;
      c0tx_valid     <= 1'b0;
      c0tx_addr      <= '0;
      c0tx_mdata     <= '0;
      port_rsp_valid <= '0;
      port_rsp_mdata <= '0;
      port_rsp_data  <= '0;
      err_sticky     <= 1'b0;
      idle           <= 1'b1;
    end else begin
      c0tx_valid <= grant_vld;
      if (grant_vld) begin
        ptr        <= ptr_nxt;
        c0tx_addr  <= head_addr[grant];
        c0tx_mdata <= {grant, head_tag[grant]};
      end
      port_rsp_valid <= rsp_hit;
      if (rsp_hit != '0) begin
        port_rsp_mdata <= c0rx_mdata[UM_W-1:0];
        port_rsp_data  <= c0rx_data;
      end
      if (rx_bad) err_sticky <= 1'b1;
      idle <= (&empty) && (&cnt_zero);
    end
  end
endmodule

// File: tb/tb_cci_rd_port_mux.sv
// Directed bench for cci_rd_port_mux (4 ports, outstanding cap of 4).
module tb_cci_rd_port_mux;
  localparam int NP = 4, AW = 42, MW = 16, DW = 512, FL = 3, MO = 4, UW = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     port_rd_valid, port_rd_ready, port_rsp_valid;
  logic [NP*AW-1:0]  port_rd_addr;
  logic [NP*UW-1:0]  port_rd_mdata;
  logic              c0tx_valid, c0tx_almfull, c0rx_valid, idle, err_sticky;
  logic [AW-1:0]     c0tx_addr;
  logic [MW-1:0]     c0tx_mdata, c0rx_mdata;
  logic [DW-1:0]     c0rx_data, port_rsp_data, pat;
  logic [UW-1:0]     port_rsp_mdata;
  int                nvec = 0, nerr = 0;

  cci_rd_port_mux #(
    .NUM_PORTS(NP), .ADDR_W(AW), .MDATA_W(MW), .DATA_W(DW),
    .FIFO_DEPTH_LOG2(FL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .port_rd_valid(port_rd_valid), .port_rd_ready(port_rd_ready),
    .port_rd_addr(port_rd_addr), .port_rd_mdata(port_rd_mdata),
    .c0tx_valid(c0tx_valid), .c0tx_addr(c0tx_addr), .c0tx_mdata(c0tx_mdata),
    .c0tx_almfull(c0tx_almfull),
    .c0rx_valid(c0rx_valid), .c0rx_mdata(c0rx_mdata), .c0rx_data(c0rx_data),
    .port_rsp_valid(port_rsp_valid), .port_rsp_mdata(port_rsp_mdata),
    .port_rsp_data(port_rsp_data), .idle(idle), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    port_rd_valid = '0; port_rd_addr = '0; port_rd_mdata = '0;
    c0tx_almfull = 1'b0; c0rx_valid = 1'b0; c0rx_mdata = '0; c0rx_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_c0tx_valid got %b exp 0", c0tx_valid); end
    nvec++; if (port_rd_ready !== 4'h0) begin nerr++; $display("FAIL rst_ready got %h exp 0", port_rd_ready); end
    nvec++; if (idle !== 1'b1 || err_sticky !== 1'b0) begin nerr++; $display("FAIL rst_idle_err got %b%b exp 10", idle, err_sticky); end
    reset_n = 1'b1;
    tick();
    nvec++; if (port_rd_ready !== 4'hF) begin nerr++; $display("FAIL rst_ready_release got %h exp f", port_rd_ready); end
    // start a burst on all ports, then yank reset in the middle of a cycle
    for (int i = 0; i < NP; i++) begin
      port_rd_addr[i*AW +: AW] = AW'(42'h700 + i);
      port_rd_mdata[i*UW +: UW] = UW'(i + 1);
    end
    port_rd_valid = 4'hF;
    tick(); tick();
    nvec++; if (c0tx_valid !== 1'b1) begin nerr++; $display("FAIL rst_burst_live got %b exp 1", c0tx_valid); end
    #3 reset_n = 1'b0;
    #1;
    nvec++; if (c0tx_valid !== 1'b0 || c0tx_addr !== '0 || c0tx_mdata !== '0) begin
      nerr++; $display("FAIL rst_async_tx got v=%b a=%h m=%h exp 0", c0tx_valid, c0tx_addr, c0tx_mdata); end
    nvec++; if (port_rd_ready !== 4'h0 || port_rsp_valid !== 4'h0 || idle !== 1'b1) begin
      nerr++; $display("FAIL rst_async_ctl got rdy=%h rsp=%h idle=%b exp 0 0 1", port_rd_ready, port_rsp_valid, idle); end
    clear_inputs();
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    nvec++; if (idle !== 1'b1 || c0tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_post_idle got idle=%b v=%b exp 1 0", idle, c0tx_valid); end
    tick();
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_discarded got %b exp 0", c0tx_valid); end
  endtask

  task automatic test_single();
    do_reset();
    nvec++; if (port_rd_ready[0] !== 1'b1) begin nerr++; $display("FAIL t2_ready got %b exp 1", port_rd_ready[0]); end
    port_rd_valid = 4'b0001; port_rd_addr[0 +: AW] = 42'h100; port_rd_mdata[0 +: UW] = 14'h5;
    tick();
    port_rd_valid = '0;
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL t2_early got %b exp 0", c0tx_valid); end
    tick();
    nvec++; if (c0tx_valid !== 1'b1 || c0tx_addr !== 42'h100 || c0tx_mdata !== 16'h0005) begin
      nerr++; $display("FAIL t2_issue got v=%b a=%h m=%h exp 1 100 0005", c0tx_valid, c0tx_addr, c0tx_mdata); end
    nvec++; if (idle !== 1'b0) begin nerr++; $display("FAIL t2_busy got %b exp 0", idle); end
    tick();
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL t2_pulse got %b exp 0", c0tx_valid); end
    c0rx_valid = 1'b1; c0rx_mdata = 16'h0005; c0rx_data = pat;
    tick();
    c0rx_valid = 1'b0;
    nvec++; if (port_rsp_valid !== 4'b0001 || port_rsp_mdata !== 14'h5 || port_rsp_data !== pat) begin
      nerr++; $display("FAIL t2_rsp got v=%b m=%h exp 0001 0005", port_rsp_valid, port_rsp_mdata); end
    tick();
    nvec++; if (port_rsp_valid !== 4'b0000 || idle !== 1'b1) begin
      nerr++; $display("FAIL t2_after got v=%b idle=%b exp 0000 1", port_rsp_valid, idle); end
  endtask

  task automatic test_round_robin();
    logic [1:0] p;
    do_reset();
    for (int i = 0; i < NP; i++) begin
      port_rd_addr[i*AW +: AW] = AW'(42'h2000 + i);
      port_rd_mdata[i*UW +: UW] = UW'(14'h10 + i);
    end
    port_rd_valid = 4'hF;
    tick();
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL t3_first got %b exp 0", c0tx_valid); end
    // each port accepts exactly 4 (the cap), giving 16 back-to-back issues
    for (int k = 0; k < 16; k++) begin
      tick();
      p = 2'(k % 4);
      nvec++; if (c0tx_valid !== 1'b1 || c0tx_mdata !== {p, 14'h10 + {12'b0, p}} || c0tx_addr !== 42'h2000 + {40'b0, p}) begin
        nerr++; $display("FAIL t3_grant%0d got v=%b m=%h a=%h exp port %0d", k, c0tx_valid, c0tx_mdata, c0tx_addr, p); end
    end
    tick();
    nvec++; if (c0tx_valid !== 1'b0 || port_rd_ready !== 4'h0) begin
      nerr++; $display("FAIL t3_drain got v=%b rdy=%h exp 0 0", c0tx_valid, port_rd_ready); end
    port_rd_valid = '0;
  endtask

  task automatic test_almfull();
    do_reset();
    c0tx_almfull = 1'b1;
    port_rd_valid = 4'b1100;
    port_rd_addr[2*AW +: AW] = 42'h300; port_rd_mdata[2*UW +: UW] = 14'h22;
    port_rd_addr[3*AW +: AW] = 42'h400; port_rd_mdata[3*UW +: UW] = 14'h33;
    tick();
    port_rd_valid = '0;
    for (int i = 1; i <= 10; i++) begin
      nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL t4_hold%0d got %b exp 0", i, c0tx_valid); end
      if (i < 10) tick();
    end
    c0tx_almfull = 1'b0;
    tick();
    nvec++; if (c0tx_valid !== 1'b1 || c0tx_addr !== 42'h300 || c0tx_mdata !== 16'h8022) begin
      nerr++; $display("FAIL t4_resume got v=%b a=%h m=%h exp 1 300 8022", c0tx_valid, c0tx_addr, c0tx_mdata); end
    tick();
    nvec++; if (c0tx_valid !== 1'b1 || c0tx_addr !== 42'h400 || c0tx_mdata !== 16'hC033) begin
      nerr++; $display("FAIL t4_second got v=%b a=%h m=%h exp 1 400 c033", c0tx_valid, c0tx_addr, c0tx_mdata); end
    tick();
    nvec++; if (c0tx_valid !== 1'b0) begin nerr++; $display("FAIL t4_done got %b exp 0", c0tx_valid); end
  endtask

  task automatic test_outstanding();
    do_reset();
    port_rd_valid = 4'b0010; port_rd_addr[1*AW +: AW] = 42'h500; port_rd_mdata[1*UW +: UW] = 14'h7;
    for (int k = 1; k <= 3; k++) begin
      tick();
      nvec++; if (port_rd_ready[1] !== 1'b1) begin nerr++; $display("FAIL t5_ready%0d got %b exp 1", k, port_rd_ready[1]); end
    end
    tick();
    port_rd_valid = '0;
    nvec++; if (port_rd_ready[1] !== 1'b0) begin nerr++; $display("FAIL t5_cap got %b exp 0", port_rd_ready[1]); end
    tick();
    nvec++; if (port_rd_ready !== 4'b1101) begin nerr++; $display("FAIL t5_cap_hold got %b exp 1101", port_rd_ready); end
    c0rx_valid = 1'b1; c0rx_mdata = 16'h4007; c0rx_data = ~pat;
    tick();
    c0rx_valid = 1'b0;
    nvec++; if (port_rd_ready[1] !== 1'b1 || port_rsp_valid !== 4'b0010 || port_rsp_mdata !== 14'h7) begin
      nerr++; $display("FAIL t5_release got rdy=%b rsp=%b m=%h exp 1 0010 0007", port_rd_ready[1], port_rsp_valid, port_rsp_mdata); end
  endtask

  task automatic test_bad_id();
    do_reset();
    nvec++; if (err_sticky !== 1'b0) begin nerr++; $display("FAIL t6_clean got %b exp 0", err_sticky); end
    // top bits 101 from an "id 5"; with 2 ID bits this lands on port 2, which has nothing outstanding
    c0rx_valid = 1'b1; c0rx_mdata = 16'hA000; c0rx_data = pat;
    tick();
    c0rx_valid = 1'b0;
    nvec++; if (port_rsp_valid !== 4'b0000 || err_sticky !== 1'b1) begin
      nerr++; $display("FAIL t6_drop got rsp=%b err=%b exp 0000 1", port_rsp_valid, err_sticky); end
    tick();
    nvec++; if (idle !== 1'b1 || err_sticky !== 1'b1) begin
      nerr++; $display("FAIL t6_counters got idle=%b err=%b exp 1 1", idle, err_sticky); end
    port_rd_valid = 4'b0001; port_rd_addr[0 +: AW] = 42'h600; port_rd_mdata[0 +: UW] = 14'h3;
    tick();
    port_rd_valid = '0;
    c0rx_valid = 1'b1; c0rx_mdata = 16'h0003;
    tick();
    c0rx_valid = 1'b0;
    nvec++; if (port_rsp_valid !== 4'b0001 || port_rsp_mdata !== 14'h3 || err_sticky !== 1'b1) begin
      nerr++; $display("FAIL t6_good got rsp=%b m=%h err=%b exp 0001 0003 1", port_rsp_valid, port_rsp_mdata, err_sticky); end
  endtask

  initial begin
    pat = {8{64'h0123_4567_89AB_CDEF}};
    test_reset();
    test_single();
    test_round_robin();
    test_almfull();
    test_outstanding();
    test_bad_id();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
